// File: rtl/lisa_lsu_if.sv
// Core request/response and data-memory port of the LISA load/store unit.
// The master side is the core plus memory; the slave side is the LSU.
interface lisa_lsu_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_write_en, mem_addr, mem_write_data
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_write_en, mem_addr, mem_write_data
  );
endinterface

// File: rtl/lisa_lsu.sv
// LISA load/store unit: one request at a time, sub-word stores done as
// read-modify-write because the data memory always writes a full word.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// LOAD   | memory read of addr_q, extended result captured at the edge
// RMW_RD | read of the word under a sub-word store, merged into wdata_q
// STORE  | single-cycle write strobe of wdata_q at addr_q
// RESP   | one-cycle response pulse to the core
module lisa_lsu #(
  parameter bit ALIGN_CHECK = 1'b0,
  parameter int ADDR_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  lisa_lsu_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

  state_t            state;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              misaligned;
  logic [31:0]       load_ext;
  logic [31:0]       merge_word;
  logic              mem_active;

  always_comb begin
    misaligned = 1'b0;
    if (bus.req_size == 2'd1)
      misaligned = bus.req_addr[0];
    else if (bus.req_size[1])
      misaligned = (bus.req_addr[1:0] != 2'b00);
  end

  always_comb begin
    load_ext = bus.mem_read_data;
    case (size_q)
      2'd0:    load_ext = {{24{signed_q & bus.mem_read_data[7]}},  bus.mem_read_data[7:0]};
      2'd1:    load_ext = {{16{signed_q & bus.mem_read_data[15]}}, bus.mem_read_data[15:0]};
      default: load_ext = bus.mem_read_data;
    endcase
  end

  always_comb begin
    if (size_q == 2'd0)
      merge_word = {bus.mem_read_data[31:8], wdata_q[7:0]};
    else
      merge_word = {bus.mem_read_data[31:16], wdata_q[15:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            if (ALIGN_CHECK && misaligned) begin
              err_q <= 1'b1;
              state <= RESP;
            end else if (!bus.req_write)
              state <= LOAD;
            else if (bus.req_size[1])
              state <= STORE;
            else
              state <= RMW_RD;
          end
        end
        LOAD: begin
          rdata_q <= load_ext;
          state   <= RESP;
        end
        RMW_RD: begin
          wdata_q <= merge_word;
          state   <= STORE;
        end
        STORE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port is decoded straight from the state register, so an async
  // reset kills any in-flight access in the same instant.
  assign mem_active         = (state == LOAD) || (state == RMW_RD) || (state == STORE);
  assign bus.mem_addr       = mem_active ? addr_q : '0;
  assign bus.mem_write_en   = (state == STORE);
  assign bus.mem_write_data = (state == STORE) ? wdata_q : 32'd0;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_lisa_lsu.sv
// Drives identical requests into an ALIGN_CHECK=1 and an ALIGN_CHECK=0 unit,
// each with its own byte memory, and checks against a byte-level reference model.
module tb_lisa_lsu;
  localparam int AW  = 16;
  localparam int MSZ = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lisa_lsu_if #(.ADDR_W(AW)) bus0 ();
  lisa_lsu_if #(.ADDR_W(AW)) bus1 ();

  lisa_lsu #(.ALIGN_CHECK(1'b1), .ADDR_W(AW)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  lisa_lsu #(.ALIGN_CHECK(1'b0), .ADDR_W(AW)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic          req_signed = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'd0;

  assign bus0.req_valid  = req_valid;   assign bus1.req_valid  = req_valid;
  assign bus0.req_write  = req_write;   assign bus1.req_write  = req_write;
  assign bus0.req_size   = req_size;    assign bus1.req_size   = req_size;
  assign bus0.req_signed = req_signed;  assign bus1.req_signed = req_signed;
  assign bus0.req_addr   = req_addr;    assign bus1.req_addr   = req_addr;
  assign bus0.req_wdata  = req_wdata;   assign bus1.req_wdata  = req_wdata;

  logic          rv[2], rdy[2], rerr[2], mwe[2];
  logic [31:0]   rdat[2], mwd[2], rdw[2];
  logic [AW-1:0] maddr[2];

  assign rv[0] = bus0.resp_valid;    assign rv[1] = bus1.resp_valid;
  assign rdy[0] = bus0.req_ready;    assign rdy[1] = bus1.req_ready;
  assign rerr[0] = bus0.resp_err;    assign rerr[1] = bus1.resp_err;
  assign rdat[0] = bus0.resp_rdata;  assign rdat[1] = bus1.resp_rdata;
  assign mwe[0] = bus0.mem_write_en; assign mwe[1] = bus1.mem_write_en;
  assign mwd[0] = bus0.mem_write_data; assign mwd[1] = bus1.mem_write_data;
  assign maddr[0] = bus0.mem_addr;   assign maddr[1] = bus1.mem_addr;
  assign bus0.mem_read_data = rdw[0];
  assign bus1.mem_read_data = rdw[1];

  logic [7:0]  mem  [2][MSZ];
  logic [7:0]  rmem [2][MSZ];
  int          we_cnt[2];
  logic [AW-1:0] we_addr[2];
  logic [31:0] we_data[2];

  int tests = 0;
  int fails = 0;

  // Memory: combinational little-endian read, bytes beyond MSZ read as 0.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      rdw[d] = 32'd0;
      for (int k = 0; k < 4; k++)
        if (int'(maddr[d]) + k < MSZ) rdw[d][8*k +: 8] = mem[d][int'(maddr[d]) + k];
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mwe[d]) begin
        we_cnt[d] = we_cnt[d] + 1;
        we_addr[d] = maddr[d];
        we_data[d] = mwd[d];
        for (int k = 0; k < 4; k++)
          if (int'(maddr[d]) + k < MSZ) mem[d][int'(maddr[d]) + k] = mwd[d][8*k +: 8];
      end
    end
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(int d, int a, int sz, bit sgn);
    longint v = 0;
    int n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    for (int k = 0; k < n; k++)
      if (a + k < MSZ) v += longint'(rmem[d][a + k]) << (8 * k);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic poke(input int a, input logic [31:0] w);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) begin
        mem[d][a + k]  = w[8*k +: 8];
        rmem[d][a + k] = w[8*k +: 8];
      end
  endtask

  task automatic run_req(input bit w, input int sz, input bit sgn, input int a,
                         input logic [31:0] wd, input bit hold,
                         output logic [31:0] got0, output logic [31:0] got1);
    bit mis, h;
    int lat[2], seen[2], pulses[2], we0[2], rdy_bad[2], n;
    bit err[2];
    logic [31:0] exp_rd[2], grd[2];
    logic gerr[2];
    mis = (sz == 1 && (a % 2) != 0) || (sz >= 2 && (a % 4) != 0);
    h = hold && !mis;
    for (int d = 0; d < 2; d++) begin
      err[d] = (d == 0) && mis;
      lat[d] = err[d] ? 1 : ((!w || sz >= 2) ? 2 : 3);
      exp_rd[d] = (w || err[d]) ? 32'd0 : ref_load(d, a, sz, sgn);
      we0[d] = we_cnt[d];
      seen[d] = 0; pulses[d] = 0; rdy_bad[d] = 0;
      grd[d] = 32'd0; gerr[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("ready_before", d, 32'(rdy[d]), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz[1:0]; req_signed = sgn;
    req_addr = a[AW-1:0]; req_wdata = wd;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rv[d]) begin
          pulses[d]++;
          if (seen[d] == 0) begin seen[d] = c; grd[d] = rdat[d]; gerr[d] = rerr[d]; end
        end
        if (rdy[d] !== (c > lat[d])) rdy_bad[d]++;
      end
      if (!h || c >= lat[1]) req_valid = 1'b0;
      else begin
        req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = AW'($urandom); req_wdata = $urandom;
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk("latency", d, 32'(seen[d]), 32'(lat[d]));
      chk("resp_pulses", d, 32'(pulses[d]), 32'd1);
      chk("resp_rdata", d, grd[d], exp_rd[d]);
      chk("resp_err", d, 32'(gerr[d]), 32'(err[d]));
      chk("write_pulses", d, 32'(we_cnt[d] - we0[d]), (w && !err[d]) ? 32'd1 : 32'd0);
      if (w && !err[d]) chk("write_addr", d, 32'(we_addr[d]), 32'(a[AW-1:0]));
      chk("ready_pattern", d, 32'(rdy_bad[d]), 32'd0);
      if (w && !err[d]) begin
        n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        for (int k = 0; k < n; k++)
          if (a + k < MSZ) rmem[d][a + k] = wd[8*k +: 8];
      end
    end
    got0 = grd[0];
    got1 = grd[1];
  endtask

  task automatic check_mem();
    int diffs;
    for (int d = 0; d < 2; d++) begin
      diffs = 0;
      for (int i = 0; i < MSZ; i++) if (mem[d][i] !== rmem[d][i]) diffs++;
      chk("mem_contents", d, 32'(diffs), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ready"}, d, 32'(rdy[d]), 32'd1);
      chk({tag, "_resp_valid"}, d, 32'(rv[d]), 32'd0);
      chk({tag, "_resp_rdata"}, d, rdat[d], 32'd0);
      chk({tag, "_resp_err"}, d, 32'(rerr[d]), 32'd0);
      chk({tag, "_mem_we"}, d, 32'(mwe[d]), 32'd0);
      chk({tag, "_mem_addr"}, d, 32'(maddr[d]), 32'd0);
      chk({tag, "_mem_wdata"}, d, mwd[d], 32'd0);
    end
  endtask

  initial begin
    logic [31:0] g0, g1;
    logic [7:0] b;
    int wc[2];
    for (int d = 0; d < 2; d++) begin we_cnt[d] = 0; we_addr[d] = '0; we_data[d] = 32'd0; end
    for (int i = 0; i < MSZ; i++) begin
      b = 8'($urandom);
      for (int d = 0; d < 2; d++) begin mem[d][i] = b; rmem[d][i] = b; end
    end

    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Word store then word load.
    run_req(1'b1, 2, 1'b0, 'h10, 32'hDEADBEEF, 1'b0, g0, g1);
    chk("store_word_data", 1, we_data[1], 32'hDEADBEEF);
    run_req(1'b0, 2, 1'b1, 'h10, 32'd0, 1'b0, g0, g1);
    chk("load_word", 0, g0, 32'hDEADBEEF);
    chk("load_word", 1, g1, 32'hDEADBEEF);

    // Byte read-modify-write.
    poke('h20, 32'h11223344);
    run_req(1'b1, 0, 1'b0, 'h20, 32'h000000AA, 1'b0, g0, g1);
    chk("rmw_write_data", 0, we_data[0], 32'h112233AA);
    chk("rmw_write_data", 1, we_data[1], 32'h112233AA);
    run_req(1'b0, 2, 1'b0, 'h20, 32'd0, 1'b0, g0, g1);
    chk("rmw_readback", 1, g1, 32'h112233AA);

    // Sign and zero extension.
    poke('h30, 32'h000080F0);
    run_req(1'b0, 0, 1'b1, 'h30, 32'd0, 1'b0, g0, g1);
    chk("byte_signed", 1, g1, 32'hFFFFFFF0);
    run_req(1'b0, 0, 1'b0, 'h30, 32'd0, 1'b0, g0, g1);
    chk("byte_unsigned", 1, g1, 32'h000000F0);
    run_req(1'b0, 1, 1'b1, 'h30, 32'd0, 1'b0, g0, g1);
    chk("half_signed", 1, g1, 32'hFFFF80F0);
    run_req(1'b0, 1, 1'b0, 'h30, 32'd0, 1'b0, g0, g1);
    chk("half_unsigned", 1, g1, 32'h000080F0);

    // Misaligned word store: rejected with ALIGN_CHECK=1, passes through otherwise.
    run_req(1'b1, 2, 1'b0, 'h31, 32'hCAFEF00D, 1'b0, g0, g1);
    run_req(1'b0, 2, 1'b0, 'h30, 32'd0, 1'b0, g0, g1);
    chk("misaligned_unchanged", 0, g0, 32'h000080F0);
    chk("misaligned_written", 1, g1, 32'hFEF00DF0);

    // Held req_valid with changing data while busy.
    run_req(1'b1, 1, 1'b0, 'h42, 32'h0000BEEF, 1'b1, g0, g1);
    run_req(1'b0, 1, 1'b1, 'h42, 32'd0, 1'b1, g0, g1);
    chk("held_half_load", 1, g1, 32'hFFFFBEEF);
    run_req(1'b1, 2, 1'b0, 'h44, 32'h01234567, 1'b1, g0, g1);

    for (int i = 0; i < 150; i++)
      run_req(1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, MSZ + 6),
              $urandom, ($urandom_range(0, 3) == 0), g0, g1);

    // Asynchronous reset during RMW_RD of a byte store.
    for (int d = 0; d < 2; d++) wc[d] = we_cnt[d];
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = AW'('h50); req_wdata = 32'h00000077;
    @(posedge clk);
    #2 req_valid = 1'b0;
    for (int d = 0; d < 2; d++) chk("rmw_rd_addr", d, 32'(maddr[d]), 32'h50);
    rst = 1'b1;
    #1 check_reset_outputs("midop_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("midop_no_write", d, 32'(we_cnt[d] - wc[d]), 32'd0);
      chk("ready_after_reset", d, 32'(rdy[d]), 32'd1);
    end

    run_req(1'b0, 2, 1'b0, 'h50, 32'd0, 1'b0, g0, g1);
    check_mem();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
